// File: rtl/ysyx_23060221_uart_pkg.sv
// Shared constants and FSM state types for the console UART AXI slave.
package ysyx_23060221_uart_pkg;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] UART_BASE = 32'ha00003f8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/ysyx_23060221_sync_fifo.sv
// Single-clock FIFO with fall-through read data; DEPTH must be a power of two.
module ysyx_23060221_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
endmodule

// File: rtl/ysyx_23060221_uart_slave.sv
// AXI4 console slave: write beats feed a TX FIFO drained onto an 8N1 line,
// reads return live {tx_busy, fifo_empty, fifo_full} status.
module ysyx_23060221_uart_slave
  import ysyx_23060221_uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        awready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  output logic        wready,
  input  logic        wvalid,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  input  logic        bready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        arready,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        rready,
  output logic        rvalid,
  output logic [1:0]  rresp,
  output logic [63:0] rdata,
  output logic        rlast,
  output logic [3:0]  rid,
  output logic        tx
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  wr_state_e r_wr_state, w_wr_state_next;
  rd_state_e r_rd_state, w_rd_state_next;
  tx_state_e r_tx_state, w_tx_state_next;

  logic [3:0]        r_bid, r_rid;
  logic [2:0]        r_off;
  logic [7:0]        r_arlen, r_beat;
  logic [BAUD_W-1:0] r_baud, w_baud_next;
  logic [2:0]        r_bit, w_bit_next;
  logic [7:0]        r_shift, w_shift_next;
  logic              r_tx, w_tx_next;

  logic              w_push, w_pop, w_full, w_empty, w_tx_busy, w_rlast;
  logic [7:0]        w_push_data, w_fifo_dout;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_unused;

  // The decoder upstream already routed only console traffic here.
  assign w_unused = ^{awaddr[31:3] ^ UART_BASE[31:3], awlen, awsize, awburst,
                      araddr, arsize, arburst, w_fifo_count};

  ysyx_23060221_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_data),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_state <= W_IDLE;
      r_bid      <= '0;
      r_off      <= '0;
    end else begin
      r_wr_state <= w_wr_state_next;
      if (awvalid && awready) begin
        r_bid <= awid;
        r_off <= awaddr[2:0];
      end
    end
  end

  assign w_push_data = wdata[{r_off, 3'b000} +: 8];

  always_comb begin
    w_wr_state_next = r_wr_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    w_push  = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_wr_state_next = W_DATA;
      end
      W_DATA: begin
        wready = !w_full;
        if (wvalid && !w_full) begin
          w_push = wstrb[r_off];
          if (wlast) w_wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_wr_state_next = W_IDLE;
      end
      default: w_wr_state_next = W_IDLE;
    endcase
  end

  assign bid   = r_bid;
  assign bresp = RESP_OKAY;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_state <= R_IDLE;
      r_rid      <= '0;
      r_arlen    <= '0;
      r_beat     <= '0;
    end else begin
      r_rd_state <= w_rd_state_next;
      if (arvalid && arready) begin
        r_rid   <= arid;
        r_arlen <= arlen;
        r_beat  <= '0;
      end else if (rvalid && rready) begin
        r_beat <= r_beat + 8'd1;
      end
    end
  end

  assign w_rlast = (r_beat == r_arlen);

  always_comb begin
    w_rd_state_next = r_rd_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rdata   = '0;
    case (r_rd_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) w_rd_state_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = w_rlast;
        rdata  = {61'b0, w_tx_busy, w_empty, w_full};
        if (rready && w_rlast) w_rd_state_next = R_IDLE;
      end
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  assign rid   = r_rid;
  assign rresp = RESP_OKAY;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_baud     <= w_baud_next;
      r_bit      <= w_bit_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
    end
  end

  // The line level is registered from the current state, so it trails the
  // state by one cycle while every bit still lasts CLKS_PER_BIT cycles.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_baud_next     = r_baud;
    w_bit_next      = r_bit;
    w_shift_next    = r_shift;
    w_pop           = 1'b0;
    w_tx_next       = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        w_baud_next = '0;
        if (!w_empty) begin
          w_pop           = 1'b1;
          w_shift_next    = w_fifo_dout;
          w_tx_state_next = TX_START;
        end
      end
      TX_START: begin
        w_tx_next = 1'b0;
        if (r_baud == BAUD_LAST) begin
          w_baud_next     = '0;
          w_bit_next      = '0;
          w_tx_state_next = TX_DATA;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      TX_DATA: begin
        w_tx_next = r_shift[0];
        if (r_baud == BAUD_LAST) begin
          w_baud_next  = '0;
          w_shift_next = r_shift >> 1;
          if (r_bit == 3'd7) w_tx_state_next = TX_STOP;
          else               w_bit_next      = r_bit + 3'd1;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      TX_STOP: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_next = '0;
          if (!w_empty) begin
            w_pop           = 1'b1;
            w_shift_next    = w_fifo_dout;
            w_tx_state_next = TX_START;
          end else begin
            w_tx_state_next = TX_IDLE;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  assign w_tx_busy = (r_tx_state != TX_IDLE);
  assign tx        = r_tx;
endmodule

// File: tb/tb_ysyx_23060221_uart_slave.sv
// Scoreboard bench: stimulus pushes expected B/R/TX items, monitors pop and compare.
module tb_ysyx_23060221_uart_slave;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [31:0] BASE = 32'ha00003f8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic awready, awvalid, wready, wvalid, wlast, bready, bvalid;
  logic arready, arvalid, rready, rvalid, rlast, tx;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, arid, bid, rid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;

  ysyx_23060221_uart_slave #(.FIFO_DEPTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata),
    .rlast(rlast), .rid(rid), .tx(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0]  id;
    logic        last;
    logic [63:0] mask;
    logic [63:0] val;
  } r_exp_t;

  logic [3:0] b_exp[$];
  r_exp_t     r_exp[$];
  logic [7:0] tx_exp[$];
  int         frame_starts[$];
  logic       mon_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
  endtask

  task automatic r_expect(input logic [3:0] id, input logic last, input logic [63:0] mask,
                          input logic [63:0] val);
    r_exp_t e;
    e.id = id; e.last = last; e.mask = mask; e.val = val;
    r_exp.push_back(e);
  endtask

  // B monitor
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bvalid && bready) begin
        $display("B  bid=%0d bresp=%0d @%0d", bid, bresp, cyc);
        if (b_exp.size() == 0) begin
          n_checks++;
          $display("FAIL b_unexpected got bid=%0d exp=no response", bid);
        end else begin
          e = b_exp.pop_front();
          chk("bid", {60'b0, bid}, {60'b0, e});
          chk("bresp", {62'b0, bresp}, 64'h0);
        end
      end
    end
  end

  // R monitor
  initial begin
    r_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rvalid && rready) begin
        $display("R  rid=%0d rlast=%0d rdata=0x%0h @%0d", rid, rlast, rdata, cyc);
        if (r_exp.size() == 0) begin
          n_checks++;
          $display("FAIL r_unexpected got rid=%0d exp=no beat", rid);
        end else begin
          e = r_exp.pop_front();
          chk("rid", {60'b0, rid}, {60'b0, e.id});
          chk("rlast", {63'b0, rlast}, {63'b0, e.last});
          chk("rdata", rdata & e.mask, e.val);
          chk("rresp", {62'b0, rresp}, 64'h0);
        end
      end
    end
  end

  // TX monitor: samples mid-bit, aborts a frame when reset is seen
  initial begin
    int ph;
    int st;
    logic [9:0] bits;
    logic [7:0] e;
    ph = -1; st = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ph = -1;
        mon_busy = 1'b0;
      end else if (ph < 0) begin
        if (tx == 1'b0) begin
          ph = 0;
          st = cyc;
          mon_busy = 1'b1;
          bits = '0;
        end
      end else begin
        ph++;
        if (ph % CPB == CPB / 2) bits[ph / CPB] = tx;
        if (ph == 9 * CPB + CPB / 2) begin
          frame_starts.push_back(st);
          $display("TX byte=0x%02h start=%0d", bits[8:1], st);
          if (tx_exp.size() == 0) begin
            n_checks++;
            $display("FAIL tx_unexpected got=0x%02h exp=no frame", bits[8:1]);
          end else begin
            e = tx_exp.pop_front();
            chk("tx_start_bit", {63'b0, bits[0]}, 64'h0);
            chk("tx_byte", {56'b0, bits[8:1]}, {56'b0, e});
            chk("tx_stop_bit", {63'b0, bits[9]}, 64'h1);
          end
          ph = -1;
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic aw_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         output int hs);
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = 3'd0; awburst = 2'b01;
    hs = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (awready) begin
        @(posedge clk); #1;
        hs = cyc;
        break;
      end
    end
    awvalid = 1'b0;
    if (hs < 0) begin
      n_checks++;
      $display("FAIL aw_timeout got=no handshake exp=handshake");
    end
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         output int hs);
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = 3'd3; arburst = 2'b01;
    hs = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk); #1;
        hs = cyc;
        break;
      end
    end
    arvalid = 1'b0;
    if (hs < 0) begin
      n_checks++;
      $display("FAIL ar_timeout got=no handshake exp=handshake");
    end
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last,
                        output int hs, output int stalls);
    wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
    hs = -1; stalls = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (wready) begin
        @(posedge clk); #1;
        hs = cyc;
        break;
      end
      stalls++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (hs < 0) begin
      n_checks++;
      $display("FAIL w_timeout got=no handshake exp=handshake");
    end
  endtask

  task automatic wait_drain(input int bound, input string name);
    int i;
    for (i = 0; i < bound; i++) begin
      if (b_exp.size() == 0 && r_exp.size() == 0 && tx_exp.size() == 0 && !mon_busy) break;
      @(posedge clk); #1;
    end
    if (i == bound) begin
      n_checks++;
      $display("FAIL %s_drain got b=%0d r=%0d tx=%0d pending exp=0", name,
               b_exp.size(), r_exp.size(), tx_exp.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, hs0, hs_aw, hs_ar, st, stalls;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
    bready = 1'b1; rready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", {63'b0, awready}, 64'h1);
    chk("rst_arready", {63'b0, arready}, 64'h1);
    chk("rst_wready", {63'b0, wready}, 64'h0);
    chk("rst_bvalid", {63'b0, bvalid}, 64'h0);
    chk("rst_rvalid", {63'b0, rvalid}, 64'h0);
    chk("rst_rlast", {63'b0, rlast}, 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_bid_bresp", {58'b0, bid, bresp}, 64'h0);
    chk("rst_rid_rresp", {58'b0, rid, rresp}, 64'h0);
    chk("rst_tx", {63'b0, tx}, 64'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write 'A'
    b_exp.push_back(4'd3);
    tx_exp.push_back(8'h41);
    frame_starts.delete();
    aw_send(BASE, 4'd3, 8'd0, hs);
    w_send(64'h41, 8'h01, 1'b1, hs, stalls);
    wait_drain(400, "single");
    if (frame_starts.size() > 0) chk("single_frame_latency", 64'(frame_starts[0] - hs), 64'd2);
    else begin n_checks++; $display("FAIL single_frame_latency got=no frame exp=2"); end

    // Status read while transmitting
    b_exp.push_back(4'd1);
    tx_exp.push_back(8'h42);
    aw_send(BASE, 4'd1, 8'd0, hs);
    w_send(64'h42, 8'h01, 1'b1, hs, stalls);
    repeat (20) @(posedge clk);
    #1;
    r_expect(4'd5, 1'b0, ALL, 64'h6);
    r_expect(4'd5, 1'b1, ALL, 64'h6);
    ar_send(BASE, 4'd5, 8'd1, hs);
    wait_drain(400, "busy_read");

    // Beat with no strobe: accepted, nothing transmitted
    repeat (30) @(posedge clk);
    #1;
    b_exp.push_back(4'd7);
    aw_send(BASE, 4'd7, 8'd0, hs);
    w_send(64'h99, 8'h00, 1'b1, hs, stalls);
    repeat (30) @(posedge clk);
    #1;
    r_expect(4'd2, 1'b1, ALL, 64'h2);
    ar_send(BASE, 4'd2, 8'd0, hs);
    wait_drain(100, "nostrb");

    // Ten-beat burst through an eight-entry FIFO
    b_exp.push_back(4'd9);
    for (int k = 0; k < 10; k++) tx_exp.push_back(8'h30 + 8'(k));
    frame_starts.delete();
    aw_send(BASE, 4'd9, 8'd9, hs);
    hs0 = 0;
    st = 0;
    for (int k = 0; k < 10; k++) begin
      w_send({56'b0, 8'h30 + 8'(k)}, 8'h01, (k == 9), hs, stalls);
      if (k == 0) hs0 = hs;
      st += stalls;
    end
    chk("burst_wready_stall_cycles", 64'(st), 64'd153);
    chk("burst_last_beat_delay", 64'(hs - hs0), 64'd162);
    wait_drain(2500, "burst");
    if (frame_starts.size() == 10) begin
      chk("burst_first_frame_latency", 64'(frame_starts[0] - hs0), 64'd2);
      for (int k = 1; k < 10; k++)
        chk("burst_frame_gap", 64'(frame_starts[k] - frame_starts[k-1]), 64'(FRAME));
    end else begin
      n_checks++;
      $display("FAIL burst_frame_count got=%0d exp=10", frame_starts.size());
    end

    // Reset in the middle of a frame of zero data bits
    repeat (20) @(posedge clk);
    #1;
    b_exp.push_back(4'd2);
    tx_exp.push_back(8'h00);
    aw_send(BASE, 4'd2, 8'd0, hs);
    w_send(64'h00, 8'h01, 1'b1, hs, stalls);
    repeat (40) @(posedge clk);
    #1;
    chk("pre_reset_tx_low", {63'b0, tx}, 64'h0);
    tx_exp.delete();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tx", {63'b0, tx}, 64'h1);
    chk("midrst_awready", {63'b0, awready}, 64'h1);
    chk("midrst_arready", {63'b0, arready}, 64'h1);
    rst_n = 1'b1;
    r_expect(4'd6, 1'b1, ALL, 64'h2);
    ar_send(BASE, 4'd6, 8'd0, hs);
    b_exp.push_back(4'd4);
    tx_exp.push_back(8'h5A);
    aw_send(BASE, 4'd4, 8'd0, hs);
    w_send(64'h5A, 8'h01, 1'b1, hs, stalls);
    wait_drain(400, "post_reset");

    // Concurrent AW/AR with stalled B and R; byte lane 3
    bready = 1'b0;
    rready = 1'b0;
    b_exp.push_back(4'd11);
    tx_exp.push_back(8'hC3);
    r_expect(4'd12, 1'b1, 64'h0, 64'h0);
    fork
      aw_send(BASE + 32'd3, 4'd11, 8'd0, hs_aw);
      ar_send(BASE, 4'd12, 8'd0, hs_ar);
    join
    chk("concurrent_same_cycle", 64'(hs_ar), 64'(hs_aw));
    w_send(64'h0000_0000_C300_0000, 8'h08, 1'b1, hs, stalls);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_b", {59'b0, bvalid, bid}, {59'b0, 1'b1, 4'd11});
      chk("hold_r", {58'b0, rvalid, rlast, rid}, {58'b0, 1'b1, 1'b1, 4'd12});
    end
    @(posedge clk); #1;
    bready = 1'b1;
    rready = 1'b1;
    wait_drain(400, "concurrent");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
